// File: rtl/instr_encoder.sv
// ============================================================================
// Module  : instr_encoder
// Brief   : Encodes MIPS R/I-class fields into words and writes them to memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    output logic [15:0] wr_count,
    output logic        err
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] wr_count_q,  wr_count_d;
    logic        err_q,       err_d;

    logic [5:0]  opcode;
    logic        supported;
    logic [31:0] enc_word;
    logic        accept;

    always_comb begin
        opcode    = 6'b000000;
        supported = 1'b1;
        case (op_sel)
            4'd0:    opcode = 6'b000000;
            4'd1:    opcode = 6'b100011;
            4'd2:    opcode = 6'b101011;
            4'd3:    opcode = 6'b000100;
            4'd4:    opcode = 6'b001000;
            4'd5:    opcode = 6'b001100;
            4'd6:    opcode = 6'b001101;
            4'd7:    opcode = 6'b001010;
            default: supported = 1'b0;
        endcase
        if (op_sel == 4'd0) begin
            enc_word = {6'b000000, rs, rt, rd, shamt, funct};
        end else begin
            enc_word = {opcode, rs, rt, imm};
        end
    end

    // Ready depends only on state, reset and base_load, never on in_valid.
    assign in_ready = rst_n & (state_q == IDLE) & ~base_load;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_count_d  = wr_count_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (base_load) begin
                    mem_addr_d = {base_addr[31:2], 2'b00};
                end else if (accept) begin
                    if (supported) begin
                        mem_wdata_d = enc_word;
                        state_d     = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mem_gnt) begin
                    state_d    = IDLE;
                    mem_addr_d = mem_addr_q + 32'd4;
                    if (wr_count_q != 16'hFFFF) begin
                        wr_count_d = wr_count_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            wr_count_q  <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wr_count_q  <= wr_count_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = (state_q == WRITE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_count  = wr_count_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1, instruction fields present.
REQ-004 SHALL have port in_ready, output, 1, encoder accepts fields this cycle.
REQ-005 SHALL have port op_sel, input, 4, instruction class: 0=R, 1=lw, 2=sw, 3=beq, 4=addi, 5=andi, 6=ori, 7=slti; 8-15 unsupported.
REQ-006 SHALL have ports rs, rt, rd, shamt, input, 5 each, register and shift fields.
REQ-007 SHALL have port funct, input, 6, R-type function field.
REQ-008 SHALL have port imm, input, 16, I-type immediate.
REQ-009 SHALL have ports base_load (input, 1) and base_addr (input, 32), which load the write address.
REQ-010 SHALL have ports mem_req (output, 1), mem_addr (output, 32), mem_wdata (output, 32) and mem_gnt (input, 1), forming the instruction-memory write port.
REQ-011 SHALL have ports wr_count (output, 16), the number of words written, and err (output, 1), a sticky flag for unsupported ops.

Function
REQ-012 SHALL implement FSM states IDLE and WRITE.
REQ-013 SHALL drive in_ready = 1 only in IDLE with base_load = 0.
REQ-014 SHALL, on base_load in IDLE, set mem_addr <= {base_addr[31:2],2'b00} next cycle; base_load in WRITE SHALL be ignored.
REQ-015 SHALL, on accept (in_valid & in_ready) of a supported op, register the encoded word into mem_wdata and enter WRITE next cycle.
REQ-016 SHALL encode R as {6'b000000, rs, rt, rd, shamt, funct}.
REQ-017 SHALL encode I-class ops as {opcode, rs, rt, imm}, with opcodes lw=100011, sw=101011, beq=000100, addi=001000, andi=001100, ori=001101, slti=001010; rd/shamt/funct SHALL be ignored.
REQ-018 SHALL hold mem_req = 1 throughout WRITE; mem_addr and mem_wdata SHALL be stable while mem_req = 1.
REQ-019 SHALL, in the cycle mem_req & mem_gnt, return to IDLE next cycle, add 4 to mem_addr (modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000) and increment wr_count.
REQ-020 SHALL saturate wr_count at 0xFFFF.
REQ-021 SHALL, on accept of an unsupported op_sel, set err = 1 and leave mem_addr, wr_count and mem_wdata unchanged; it SHALL stay in IDLE with in_ready = 1 next cycle.
REQ-022 SHALL keep err set until reset.
REQ-023 SHALL ignore mem_gnt outside WRITE.
REQ-024 SHALL sustain throughput of one word per two cycles when mem_gnt is already high: accept, then WRITE with grant.
REQ-025 SHALL not hold in_ready combinationally dependent on in_valid.

Reset
REQ-026 SHALL, on clk edge with rst_n = 0, enter IDLE with mem_req = 0, mem_addr = 0, mem_wdata = 0, wr_count = 0 and err = 0.
REQ-027 SHALL, when reset occurs in WRITE, abandon the pending word with no write completed and no count increment.
REQ-028 SHALL, while rst_n = 0, hold in_ready = 0.

Verification
REQ-029 SHALL verify: reset, then addi rs=1 rt=2 imm=5 with mem_gnt=1 -> mem_req one cycle later, mem_addr=0x00000000, mem_wdata=0x20220005; then mem_addr=4, wr_count=1.
REQ-030 SHALL verify: base_load base_addr=0x00400003, then lw rs=29 rt=8 imm=4 -> mem_addr=0x00400000, mem_wdata=0x8FA80004.
REQ-031 SHALL verify: R op rs=1 rt=2 rd=3 shamt=0 funct=0x20 with mem_gnt held low 3 cycles -> mem_req, mem_addr and mem_wdata=0x00221820 stable 4 cycles, in_ready=0 until grant, then wr_count=1.
REQ-032 SHALL verify: op_sel=9 accepted -> err=1, no mem_req, wr_count unchanged, in_ready=1 next cycle; a later valid op still writes.
REQ-033 SHALL verify: base_addr=0xFFFFFFFC, then two ori writes -> second mem_addr=0x00000000.
REQ-034 SHALL verify: rst_n=0 asserted during WRITE -> next cycle mem_req=0, wr_count=0, err=0, state IDLE.
